// File: rtl/rmt_cfg_pkg.sv
// Shared definitions for the stage config writers: resource codes, header layout,
// beats per entry and the writer FSM encoding.
package rmt_cfg_pkg;

  localparam logic [1:0] RES_KEY_OFF = 2'd0;
  localparam logic [1:0] RES_LOOKUP  = 2'd1;
  localparam logic [1:0] RES_ACTION  = 2'd2;

  localparam int HDR_STAGE_LSB = 0;
  localparam int HDR_STAGE_W   = 4;
  localparam int HDR_RES_LSB   = 4;
  localparam int HDR_RES_W     = 4;
  localparam int HDR_ADDR_LSB  = 8;
  localparam int HDR_CNT_LSB   = 16;
  localparam int HDR_CNT_W     = 8;

  localparam logic [1:0] BEATS_KEY_OFF = 2'd1;
  localparam logic [1:0] BEATS_LOOKUP  = 2'd2;
  localparam logic [1:0] BEATS_ACTION  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DRAIN
  } cfg_state_e;

  function automatic logic [1:0] beats_per_entry(input logic [1:0] res);
    case (res)
      RES_KEY_OFF: beats_per_entry = BEATS_KEY_OFF;
      RES_LOOKUP:  beats_per_entry = BEATS_LOOKUP;
      default:     beats_per_entry = BEATS_ACTION;
    endcase
  endfunction

endpackage

// File: rtl/cfg_entry_assembler.sv
// Collects the leading beats of a table entry; the final beat is taken straight
// from the stream by the writer, so entry_ready fires combinationally with it.
module cfg_entry_assembler
  import rmt_cfg_pkg::*;
#(
  parameter int DW = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            beat_valid,
  input  logic [DW-1:0]   beat,
  input  logic [1:0]      res,
  output logic [2*DW-1:0] held,
  output logic            entry_ready
);

  logic [1:0]    beat_cnt;
  logic [1:0]    beats_needed;
  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  assign beats_needed = beats_per_entry(res);
  assign entry_ready  = beat_valid && (beat_cnt == beats_needed - 2'd1);
  assign held         = {slot1, slot0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 2'd0;
      slot0    <= '0;
      slot1    <= '0;
    end else if (clear) begin
      beat_cnt <= 2'd0;
    end else if (beat_valid) begin
      if (entry_ready) begin
        beat_cnt <= 2'd0;
      end else begin
        beat_cnt <= beat_cnt + 2'd1;
        if (beat_cnt == 2'd0) slot0 <= beat;
        else                  slot1 <= beat;
      end
    end
  end

endmodule

// File: rtl/stage_cfg_writer.sv
// Turns stage-addressed AXI-Stream config packets into single-cycle table write
// strobes for one pipeline stage (key-offset RAM, match table, action RAM).
//
// state   | meaning
// IDLE    | waiting for a header beat
// COLLECT | gathering the beats of one entry
// WRITE   | strobe cycle, stream stalled
// DRAIN   | discarding beats up to tlast
module stage_cfg_writer
  import rmt_cfg_pkg::*;
#(
  parameter int STAGE               = 0,
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int KEY_LEN             = 197,
  parameter int ACT_LEN             = 25,
  parameter int KEY_OFF             = 18,
  parameter int ADDR_W              = 4
) (
  input  logic                           axis_clk,
  input  logic                           aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [KEY_OFF-1:0]             key_off_entry_out,
  output logic [ADDR_W-1:0]              key_off_entry_addr,
  output logic                           key_off_entry_valid,
  output logic [KEY_LEN-1:0]             lookup_din,
  output logic [KEY_LEN-1:0]             lookup_din_mask,
  output logic [ADDR_W-1:0]              lookup_din_addr,
  output logic                           lookup_din_en,
  output logic [ACT_LEN*25-1:0]          action_data_out,
  output logic [ADDR_W-1:0]              action_addr,
  output logic                           action_en,
  output logic                           cfg_done,
  output logic                           cfg_err
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int ACT_W = ACT_LEN * 25;
  localparam logic [HDR_STAGE_W-1:0] STAGE_ID = HDR_STAGE_W'(STAGE);

  cfg_state_e        state_q, state_d;
  logic              rdy_q;
  logic [1:0]        res_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        remaining_q;
  logic              last_q;

  logic          beat_acc;
  logic          hdr_for_us;
  logic          hdr_ok;
  logic          asm_clear;
  logic [2*DW-1:0] held;
  logic          entry_ready;
  logic          load_hdr;
  logic          advance;
  logic          wr_d;
  logic          done_d;
  logic          err_d;

  // rdy_q keeps tready low while (and just after) reset is asserted
  assign s_axis_tready = rdy_q && (state_q != ST_WRITE);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  assign hdr_for_us = s_axis_tdata[HDR_STAGE_LSB +: HDR_STAGE_W] == STAGE_ID;
  assign hdr_ok     = (s_axis_tdata[HDR_RES_LSB +: HDR_RES_W] <= {2'b00, RES_ACTION})
                   && (s_axis_tdata[HDR_CNT_LSB +: HDR_CNT_W] != 8'd0)
                   && !s_axis_tlast;

  cfg_entry_assembler #(.DW(DW)) u_asm (
    .clk         (axis_clk),
    .rst_n       (aresetn),
    .clear       (asm_clear),
    .beat_valid  (beat_acc && (state_q == ST_COLLECT)),
    .beat        (s_axis_tdata),
    .res         (res_q),
    .held        (held),
    .entry_ready (entry_ready)
  );

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    asm_clear = 1'b0;
    load_hdr  = 1'b0;
    advance   = 1'b0;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          asm_clear = 1'b1;
          if (!hdr_for_us) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
          end else if (hdr_ok) begin
            load_hdr = 1'b1;
            state_d  = ST_COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_COLLECT: begin
        if (beat_acc) begin
          if (entry_ready) begin
            wr_d    = 1'b1;
            done_d  = (remaining_q == 8'd1);
            state_d = ST_WRITE;
          end else if (s_axis_tlast) begin
            asm_clear = 1'b1;
            err_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        // last entry: trailing beats are an error; earlier entry: tlast means entries missing
        if (remaining_q == 8'd1) begin
          err_d   = !last_q;
          state_d = last_q ? ST_IDLE : ST_DRAIN;
        end else begin
          advance = 1'b1;
          err_d   = last_q;
          state_d = last_q ? ST_IDLE : ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (beat_acc && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q       <= 1'b0;
      res_q       <= RES_KEY_OFF;
      addr_q      <= '0;
      remaining_q <= 8'd0;
      last_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (load_hdr) begin
        res_q       <= s_axis_tdata[HDR_RES_LSB +: 2];
        addr_q      <= s_axis_tdata[HDR_ADDR_LSB +: ADDR_W];
        remaining_q <= s_axis_tdata[HDR_CNT_LSB +: HDR_CNT_W];
      end
      if (advance) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - 8'd1;
      end
      if (wr_d) last_q <= s_axis_tlast;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      key_off_entry_out   <= '0;
      key_off_entry_addr  <= '0;
      key_off_entry_valid <= 1'b0;
      lookup_din          <= '0;
      lookup_din_mask     <= '0;
      lookup_din_addr     <= '0;
      lookup_din_en       <= 1'b0;
      action_data_out     <= '0;
      action_addr         <= '0;
      action_en           <= 1'b0;
      cfg_done            <= 1'b0;
      cfg_err             <= 1'b0;
    end else begin
      key_off_entry_valid <= wr_d && (res_q == RES_KEY_OFF);
      lookup_din_en       <= wr_d && (res_q == RES_LOOKUP);
      action_en           <= wr_d && (res_q == RES_ACTION);
      cfg_done            <= done_d;
      cfg_err             <= err_d;
      if (wr_d && (res_q == RES_KEY_OFF)) begin
        key_off_entry_out  <= s_axis_tdata[KEY_OFF-1:0];
        key_off_entry_addr <= addr_q;
      end
      if (wr_d && (res_q == RES_LOOKUP)) begin
        lookup_din      <= held[KEY_LEN-1:0];
        lookup_din_mask <= s_axis_tdata[KEY_LEN-1:0];
        lookup_din_addr <= addr_q;
      end
      if (wr_d && (res_q == RES_ACTION)) begin
        action_data_out <= {s_axis_tdata[ACT_W-2*DW-1:0], held};
        action_addr     <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_stage_cfg_writer.sv
// Directed bench for stage_cfg_writer: a packet-level model predicts write/done/error
// events, and a negedge monitor matches every observed pulse against that prediction.
module tb_stage_cfg_writer;

  localparam int STAGE_TB = 2;

  logic           axis_clk = 1'b0;
  logic           aresetn;
  logic [255:0]   s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
  logic           s_axis_tready;
  logic [17:0]    key_off_entry_out;
  logic [3:0]     key_off_entry_addr;
  logic           key_off_entry_valid;
  logic [196:0]   lookup_din;
  logic [196:0]   lookup_din_mask;
  logic [3:0]     lookup_din_addr;
  logic           lookup_din_en;
  logic [624:0]   action_data_out;
  logic [3:0]     action_addr;
  logic           action_en;
  logic           cfg_done;
  logic           cfg_err;

  always #5 axis_clk = ~axis_clk;

  stage_cfg_writer #(.STAGE(STAGE_TB)) dut (
    .axis_clk            (axis_clk),
    .aresetn             (aresetn),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .key_off_entry_out   (key_off_entry_out),
    .key_off_entry_addr  (key_off_entry_addr),
    .key_off_entry_valid (key_off_entry_valid),
    .lookup_din          (lookup_din),
    .lookup_din_mask     (lookup_din_mask),
    .lookup_din_addr     (lookup_din_addr),
    .lookup_din_en       (lookup_din_en),
    .action_data_out     (action_data_out),
    .action_addr         (action_addr),
    .action_en           (action_en),
    .cfg_done            (cfg_done),
    .cfg_err             (cfg_err)
  );

  // kind: 0 key_off write, 1 lookup write, 2 action write, 3 error pulse
  typedef struct {
    int           kind;
    logic [3:0]   addr;
    logic [624:0] data;
    logic [196:0] mask;
    bit           done;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_acc = 0;
  int  stall_cnt = 0;
  int  err_seen = 0;
  int  wr_seen = 0;
  int  done_seen = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [624:0] got, input logic [624:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] hdr(input int st, input int res, input int addr, input int n);
    logic [255:0] h;
    h = {8{32'hC0DE_F00D}};
    h[3:0]   = st[3:0];
    h[7:4]   = res[3:0];
    h[15:8]  = addr[7:0];
    h[23:16] = n[7:0];
    return h;
  endfunction

  function automatic logic [255:0] pat(input int seed);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = (32'h9E37_79B9 * (seed + 1)) ^ k;
    return b;
  endfunction

  task automatic model_packet(input logic [255:0] pk[$]);
    ev_t e;
    logic [255:0] h, b0, b1, b2;
    int res, n, bpe, p, nw, base;
    h = pk[0];
    if (int'(h[3:0]) != STAGE_TB) return;
    res = int'(h[7:4]);
    n   = int'(h[23:16]);
    e.kind = 3; e.addr = 4'd0; e.data = '0; e.mask = '0; e.done = 1'b0;
    if (res > 2 || n == 0 || pk.size() == 1) begin
      exp_q.push_back(e);
      return;
    end
    bpe = res + 1;
    p   = pk.size() - 1;
    nw  = p / bpe;
    if (nw > n) nw = n;
    for (int i = 0; i < nw; i++) begin
      base = 1 + i * bpe;
      b0 = pk[base];
      b1 = (bpe > 1) ? pk[base + 1] : '0;
      b2 = (bpe > 2) ? pk[base + 2] : '0;
      e.kind = res;
      e.addr = 4'((int'(h[15:8]) + i) % 16);
      e.done = (i == n - 1);
      e.mask = '0;
      if (res == 0)      e.data = 625'(b0[17:0]);
      else if (res == 1) begin e.data = 625'(b0[196:0]); e.mask = b1[196:0]; end
      else               e.data = {b2[112:0], b1, b0};
      exp_q.push_back(e);
    end
    if (p != n * bpe) begin
      e.kind = 3; e.addr = 4'd0; e.data = '0; e.mask = '0; e.done = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  ev_t mon_e;
  logic [4:0] got_flags, exp_flags;
  always @(negedge axis_clk) begin
    if (aresetn && (key_off_entry_valid || lookup_din_en || action_en || cfg_done || cfg_err)) begin
      if (cfg_err) err_seen++;
      if (cfg_done) done_seen++;
      if (key_off_entry_valid || lookup_din_en || action_en) wr_seen++;
      got_flags = {action_en, lookup_din_en, key_off_entry_valid, cfg_done, cfg_err};
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 625'(got_flags), 625'(0));
      end else begin
        mon_e = exp_q.pop_front();
        exp_flags = {mon_e.kind == 2, mon_e.kind == 1, mon_e.kind == 0, mon_e.done, mon_e.kind == 3};
        chk("event_flags", 625'(got_flags), 625'(exp_flags));
        if (mon_e.kind < 3) begin
          chk("strobe_latency", 625'(cyc - last_acc), 625'(1));
          chk("tready_in_write", 625'(s_axis_tready), 625'(0));
        end
        case (mon_e.kind)
          0: begin
            chk("key_off_addr", 625'(key_off_entry_addr), 625'(mon_e.addr));
            chk("key_off_data", 625'(key_off_entry_out), mon_e.data);
          end
          1: begin
            chk("lookup_addr", 625'(lookup_din_addr), 625'(mon_e.addr));
            chk("lookup_data", 625'(lookup_din), mon_e.data);
            chk("lookup_mask", 625'(lookup_din_mask), 625'(mon_e.mask));
          end
          2: begin
            chk("action_addr", 625'(action_addr), 625'(mon_e.addr));
            chk("action_data", action_data_out, mon_e.data);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic send_beat(input logic [255:0] d, input logic last);
    int guard;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    guard = 0;
    while (!s_axis_tready && guard < 20) begin
      @(negedge axis_clk);
      guard++;
      stall_cnt++;
    end
    chk("beat_accepted", 625'(s_axis_tready), 625'(1));
    last_acc = cyc;
    @(negedge axis_clk);
  endtask

  task automatic send_pkt(input logic [255:0] pk[$]);
    model_packet(pk);
    for (int i = 0; i < pk.size(); i++) send_beat(pk[i], i == pk.size() - 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) @(negedge axis_clk);
    repeat (2) @(negedge axis_clk);
    chk("events_drained", 625'(exp_q.size()), 625'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, 625'(s_axis_tready), 625'(0));
    chk({tag, "_strobes"}, 625'({key_off_entry_valid, lookup_din_en, action_en, cfg_done, cfg_err}), 625'(0));
    chk({tag, "_key_off"}, 625'({key_off_entry_out, key_off_entry_addr}), 625'(0));
    chk({tag, "_lookup"}, 625'(lookup_din | lookup_din_mask), 625'(0));
    chk({tag, "_action"}, action_data_out, 625'(0));
    chk({tag, "_addrs"}, 625'({lookup_din_addr, action_addr}), 625'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [255:0] pk[$];
  logic [255:0] p1, p2, p3;
  logic [255:0] ones;
  int e0, w0, d0;

  initial begin
    aresetn = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    ones = '1;
    repeat (3) @(negedge axis_clk);
    chk_all_zero("reset");
    aresetn = 1'b1;
    @(negedge axis_clk);

    // two key-offset entries at 3 and 4
    w0 = wr_seen; d0 = done_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 0, 3, 2));
    pk.push_back(256'h15);
    pk.push_back(256'h2A);
    send_pkt(pk);
    chk("t1_writes", 625'(wr_seen - w0), 625'(2));
    chk("t1_done", 625'(done_seen - d0), 625'(1));
    chk("t1_addr_hold", 625'(key_off_entry_addr), 625'(4));
    chk("t1_data_hold", 625'(key_off_entry_out), 625'(18'h2A));

    // action entry at 15
    p1 = pat(1); p2 = pat(2); p3 = pat(3);
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 2, 15, 1));
    pk.push_back(p1); pk.push_back(p2); pk.push_back(p3);
    send_pkt(pk);
    chk("t2_action_addr", 625'(action_addr), 625'(15));
    chk("t2_action_data", action_data_out, {p3[112:0], p2, p1});

    // two action entries starting at 15: address wraps to 0
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 2, 15, 2));
    for (int i = 4; i < 10; i++) pk.push_back(pat(i));
    send_pkt(pk);
    p1 = pat(7); p2 = pat(8); p3 = pat(9);
    chk("t2_wrap_addr", 625'(action_addr), 625'(0));
    chk("t2_wrap_data", action_data_out, {p3[112:0], p2, p1});

    // lookup entry
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 1, 9, 1));
    pk.push_back(256'h1_0000_BEEF);
    pk.push_back(ones);
    send_pkt(pk);
    chk("t3_lookup_data", 625'(lookup_din), 625'(197'h1_0000_BEEF));
    chk("t3_lookup_mask", 625'(lookup_din_mask), 625'({197{1'b1}}));
    chk("t3_lookup_addr", 625'(lookup_din_addr), 625'(9));

    // two lookup entries
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 1, 6, 2));
    for (int i = 10; i < 14; i++) pk.push_back(pat(i));
    send_pkt(pk);
    chk("t3b_lookup_addr", 625'(lookup_din_addr), 625'(7));

    // packet for another stage: ignored, never stalls
    e0 = err_seen; w0 = wr_seen; stall_cnt = 0;
    pk.delete();
    pk.push_back(hdr(5, 0, 0, 4));
    for (int i = 20; i < 24; i++) pk.push_back(pat(i));
    send_pkt(pk);
    chk("t4_no_err", 625'(err_seen - e0), 625'(0));
    chk("t4_no_write", 625'(wr_seen - w0), 625'(0));
    chk("t4_no_stall", 625'(stall_cnt), 625'(0));

    // lookup cut short on its data beat
    e0 = err_seen; w0 = wr_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 1, 0, 1));
    pk.push_back(pat(30));
    send_pkt(pk);
    chk("t5_err", 625'(err_seen - e0), 625'(1));
    chk("t5_no_write", 625'(wr_seen - w0), 625'(0));

    // bad resource code, packet drained
    e0 = err_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 3, 0, 1));
    pk.push_back(pat(31));
    pk.push_back(pat(32));
    send_pkt(pk);
    chk("t6_err", 625'(err_seen - e0), 625'(1));

    // entries missing: N=3 with only two beats
    e0 = err_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 0, 14, 3));
    pk.push_back(256'h3_0001);
    pk.push_back(256'h3_0002);
    send_pkt(pk);
    chk("t7_err", 625'(err_seen - e0), 625'(1));
    chk("t7_addr", 625'(key_off_entry_addr), 625'(15));

    // trailing beats after the last entry
    e0 = err_seen; d0 = done_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 0, 0, 1));
    pk.push_back(256'h1_2345);
    pk.push_back(pat(40));
    pk.push_back(pat(41));
    send_pkt(pk);
    chk("t8_err", 625'(err_seen - e0), 625'(1));
    chk("t8_done", 625'(done_seen - d0), 625'(1));

    // zero entry count
    e0 = err_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 0, 0, 0));
    pk.push_back(pat(42));
    send_pkt(pk);
    chk("t9_err", 625'(err_seen - e0), 625'(1));

    // reset in the middle of an action entry
    send_beat(hdr(STAGE_TB, 2, 5, 1), 1'b0);
    send_beat(pat(50), 1'b0);
    send_beat(pat(51), 1'b0);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge axis_clk);
    aresetn = 1'b1;
    @(negedge axis_clk);
    w0 = wr_seen;
    pk.delete();
    pk.push_back(hdr(STAGE_TB, 0, 7, 1));
    pk.push_back(256'h2_5A5A);
    send_pkt(pk);
    chk("t10_writes", 625'(wr_seen - w0), 625'(1));
    chk("t10_key_off_data", 625'(key_off_entry_out), 625'(18'h2_5A5A));
    chk("t10_key_off_addr", 625'(key_off_entry_addr), 625'(7));
    chk("t10_action_clear", action_data_out, 625'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
